// File: rtl/apb_slave_pkg.sv
// ---------------------------------------------------------------------------
// apb_pkg
//   Shared definitions for the APB register-file slave, its bridge and bench.
//   Contents:
//     APB_AW / APB_DW    default word-address and data widths of the bus
//     apb_slv_state_e    slave handshake FSM state encoding
// ---------------------------------------------------------------------------
package apb_pkg;

  localparam int APB_AW = 8;
  localparam int APB_DW = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    READY = 2'd2
  } apb_slv_state_e;

endpackage

// File: rtl/apb_slave_if.sv
// ---------------------------------------------------------------------------
// apb_slave_if
//   APB3 bus bundle between the bridge (master) and one register-file slave.
//   Signals:
//     psel, penable, pwrite, paddr, pwdata   master -> slave
//     pready, prdata, pslverr                slave  -> master
//   Modports: master (bridge side), slave (register-file side).
// ---------------------------------------------------------------------------
interface apb_slave_if
  import apb_pkg::*;
#(
  parameter int AW = APB_AW,
  parameter int DW = APB_DW
) ();

  logic          psel;
  logic          penable;
  logic          pwrite;
  logic [AW-1:0] paddr;
  logic [DW-1:0] pwdata;
  logic          pready;
  logic [DW-1:0] prdata;
  logic          pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_slave_regfile.sv
// ---------------------------------------------------------------------------
// apb_slave_regfile
//   DEPTH x DW flop storage for the APB slave. Cleared asynchronously by
//   presetn, one synchronous write port, one combinational read port.
//   Ports:
//     pclk, presetn   clock / async active-low clear
//     we_i            write enable (caller guarantees waddr_i < DEPTH)
//     waddr_i         write word index
//     wdata_i         write data
//     raddr_i         read word index
//     rdata_o         read data (combinational)
// ---------------------------------------------------------------------------
module apb_slave_regfile #(
  parameter int DW    = 8,
  parameter int DEPTH = 64,
  parameter int IW    = 6
) (
  input  logic          pclk,
  input  logic          presetn,
  input  logic          we_i,
  input  logic [IW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic [IW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/apb_slave.sv
// ---------------------------------------------------------------------------
// apb_slave
//   APB3 register-file slave: setup/access handshake with WAIT_CYCLES wait
//   states, DEPTH-word storage, PSLVERR for word addresses >= DEPTH.
//   Ports:
//     pclk     APB clock, rising edge
//     presetn  asynchronous active-low reset
//     apb      apb_slave_if.slave bus (psel/penable/pwrite/paddr/pwdata in,
//              pready/prdata/pslverr out)
// ---------------------------------------------------------------------------
module apb_slave
  import apb_pkg::*;
#(
  parameter int AW          = APB_AW,
  parameter int DW          = APB_DW,
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 0
) (
  input  logic       pclk,
  input  logic       presetn,
  apb_slave_if.slave apb
);

  localparam int          IW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  WCNT_INIT = 4'(WAIT_CYCLES);
  localparam logic [AW:0] DEPTH_W   = (AW+1)'(DEPTH);

  function automatic logic in_range(input logic [AW-1:0] a);
    return {1'b0, a} < DEPTH_W;
  endfunction

  apb_slv_state_e state_q, state_d;

  logic [AW-1:0] addr_q,   addr_d;
  logic          wr_q,     wr_d;
  logic [DW-1:0] wdata_q,  wdata_d;
  logic [3:0]    wcnt_q,   wcnt_d;
  logic [DW-1:0] prdata_q, prdata_d;

  logic          setup;
  logic          access;
  logic [AW-1:0] rd_addr;
  logic          rd_is_wr;
  logic [DW-1:0] rdata;
  logic          mem_we;

  // psel & penable without a preceding setup phase is never a setup here,
  // so a stray access-phase cycle in IDLE is ignored.
  assign setup  = (state_q == IDLE) && apb.psel && !apb.penable;
  assign access = apb.psel && apb.penable;

  // With zero wait states READY is entered straight from the setup edge,
  // before addr_q/wr_q hold the new transfer, so read from the bus then.
  assign rd_addr  = (state_q == IDLE) ? apb.paddr  : addr_q;
  assign rd_is_wr = (state_q == IDLE) ? apb.pwrite : wr_q;

  // State register
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state_q <= IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (setup) state_d = (WAIT_CYCLES > 0) ? WAIT : READY;
      WAIT: begin
        if (!access)              state_d = IDLE;
        else if (wcnt_q == 4'd1)  state_d = READY;
      end
      READY:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Moore outputs; the write commits on the edge that ends READY and only
  // if the master is still in the access phase.
  always_comb begin
    apb.pready  = (state_q == READY);
    apb.pslverr = (state_q == READY) && !in_range(addr_q);
    mem_we      = (state_q == READY) && wr_q && in_range(addr_q) && access;
  end

  // Transfer capture, wait counter and read-data register
  always_comb begin
    addr_d   = addr_q;
    wr_d     = wr_q;
    wdata_d  = wdata_q;
    wcnt_d   = wcnt_q;
    prdata_d = prdata_q;
    if (setup) begin
      addr_d  = apb.paddr;
      wr_d    = apb.pwrite;
      wdata_d = apb.pwdata;
      wcnt_d  = WCNT_INIT;
    end else if ((state_q == WAIT) && access) begin
      wcnt_d = wcnt_q - 4'd1;
    end
    if ((state_d == READY) && (state_q != READY) && !rd_is_wr)
      prdata_d = in_range(rd_addr) ? rdata : '0;
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      addr_q   <= '0;
      wr_q     <= 1'b0;
      wdata_q  <= '0;
      wcnt_q   <= '0;
      prdata_q <= '0;
    end else begin
      addr_q   <= addr_d;
      wr_q     <= wr_d;
      wdata_q  <= wdata_d;
      wcnt_q   <= wcnt_d;
      prdata_q <= prdata_d;
    end
  end

  assign apb.prdata = prdata_q;

  apb_slave_regfile #(
    .DW    (DW),
    .DEPTH (DEPTH),
    .IW    (IW)
  ) u_regfile (
    .pclk    (pclk),
    .presetn (presetn),
    .we_i    (mem_we),
    .waddr_i (addr_q[IW-1:0]),
    .wdata_i (wdata_q),
    .raddr_i (rd_addr[IW-1:0]),
    .rdata_o (rdata)
  );

endmodule

// File: tb/tb_apb_slave.sv
module tb_apb_slave;
  import apb_pkg::*;

  localparam int AW    = APB_AW;
  localparam int DW    = APB_DW;
  localparam int DEPTH = 64;

  logic pclk = 1'b0;
  logic presetn;
  always #5 pclk = ~pclk;

  int wc [3] = '{0, 3, 2};

  apb_slave_if #(.AW(AW), .DW(DW)) if0 ();
  apb_slave_if #(.AW(AW), .DW(DW)) if1 ();
  apb_slave_if #(.AW(AW), .DW(DW)) if2 ();

  logic          psel_t    [3];
  logic          penable_t [3];
  logic          pwrite_t  [3];
  logic [AW-1:0] paddr_t   [3];
  logic [DW-1:0] pwdata_t  [3];

  assign if0.psel = psel_t[0]; assign if0.penable = penable_t[0]; assign if0.pwrite = pwrite_t[0];
  assign if0.paddr = paddr_t[0]; assign if0.pwdata = pwdata_t[0];
  assign if1.psel = psel_t[1]; assign if1.penable = penable_t[1]; assign if1.pwrite = pwrite_t[1];
  assign if1.paddr = paddr_t[1]; assign if1.pwdata = pwdata_t[1];
  assign if2.psel = psel_t[2]; assign if2.penable = penable_t[2]; assign if2.pwrite = pwrite_t[2];
  assign if2.paddr = paddr_t[2]; assign if2.pwdata = pwdata_t[2];

  apb_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut0 (.pclk(pclk), .presetn(presetn), .apb(if0));
  apb_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(3)) u_dut1 (.pclk(pclk), .presetn(presetn), .apb(if1));
  apb_slave #(.AW(AW), .DW(DW), .DEPTH(DEPTH), .WAIT_CYCLES(2)) u_dut2 (.pclk(pclk), .presetn(presetn), .apb(if2));

  function automatic logic get_pready(input int k);
    case (k)
      0:       return if0.pready;
      1:       return if1.pready;
      default: return if2.pready;
    endcase
  endfunction

  function automatic logic get_pslverr(input int k);
    case (k)
      0:       return if0.pslverr;
      1:       return if1.pslverr;
      default: return if2.pslverr;
    endcase
  endfunction

  function automatic logic [DW-1:0] get_prdata(input int k);
    case (k)
      0:       return if0.prdata;
      1:       return if1.prdata;
      default: return if2.prdata;
    endcase
  endfunction

  typedef struct {
    string         tag;
    logic          is_rd;
    logic          err;
    logic [DW-1:0] rdata;
    int            lat;
  } exp_t;

  exp_t          sbq [$];
  logic [DW-1:0] mem_m [3][DEPTH];
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One full transfer; leaves psel/penable high after the READY cycle so a
  // following call issues its setup phase in the cycle right after READY.
  task automatic xfer(input int k, input logic wr, input logic [AW-1:0] a,
                      input logic [DW-1:0] d, input string tag);
    exp_t e;
    int   cyc;
    e.tag   = tag;
    e.is_rd = !wr;
    e.err   = (int'(a) >= DEPTH);
    e.rdata = (int'(a) < DEPTH) ? mem_m[k][a] : '0;
    e.lat   = wc[k] + 1;
    sbq.push_back(e);
    if (wr && int'(a) < DEPTH) mem_m[k][a] = d;
    @(posedge pclk); #1;
    psel_t[k] = 1'b1; penable_t[k] = 1'b0; pwrite_t[k] = wr; paddr_t[k] = a; pwdata_t[k] = d;
    @(posedge pclk); #1;
    penable_t[k] = 1'b1;
    cyc = 0;
    do begin
      @(negedge pclk);
      cyc++;
    end while (!get_pready(k) && cyc < 16);
    e = sbq.pop_front();
    chk({e.tag, "_lat"}, cyc, e.lat);
    chk({e.tag, "_slverr"}, get_pslverr(k), e.err);
    if (e.is_rd) chk({e.tag, "_rdata"}, get_prdata(k), e.rdata);
  endtask

  task automatic idle(input int k, input string tag);
    @(posedge pclk); #1;
    psel_t[k] = 1'b0; penable_t[k] = 1'b0;
    @(negedge pclk);
    chk({tag, "_pready_1cyc"}, get_pready(k), 1'b0);
    chk({tag, "_slverr_low"}, get_pslverr(k), 1'b0);
  endtask

  initial begin
    presetn = 1'b0;
    for (int k = 0; k < 3; k++) begin
      psel_t[k] = 1'b0; penable_t[k] = 1'b0; pwrite_t[k] = 1'b0;
      paddr_t[k] = '0; pwdata_t[k] = '0;
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
    end
    repeat (2) @(posedge pclk);
    @(negedge pclk);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_pready%0d", k), get_pready(k), 1'b0);
      chk($sformatf("rst_slverr%0d", k), get_pslverr(k), 1'b0);
      chk($sformatf("rst_prdata%0d", k), get_prdata(k), '0);
    end
    @(posedge pclk); #1;
    presetn = 1'b1;

    // zero-wait write/read
    xfer(0, 1'b1, 8'h03, 8'hA5, "zw_wr");
    idle(0, "zw_wr");
    xfer(0, 1'b0, 8'h03, 8'h00, "zw_rd");
    idle(0, "zw_rd");

    // three wait states
    xfer(1, 1'b1, 8'h10, 8'h3C, "w3_wr");
    idle(1, "w3_wr");
    xfer(1, 1'b0, 8'h10, 8'h00, "w3_rd");
    idle(1, "w3_rd");

    // stray access phase without setup is ignored
    @(posedge pclk); #1;
    psel_t[0] = 1'b1; penable_t[0] = 1'b1; paddr_t[0] = 8'h03; pwrite_t[0] = 1'b0;
    repeat (2) @(negedge pclk);
    chk("nosetup_pready", get_pready(0), 1'b0);
    idle(0, "nosetup");

    // out-of-range read and write
    xfer(0, 1'b0, 8'h40, 8'h00, "oor_rd");
    idle(0, "oor_rd");
    xfer(0, 1'b1, 8'h40, 8'hFF, "oor_wr");
    idle(0, "oor_wr");
    for (int a = 0; a < DEPTH; a++) xfer(0, 1'b0, AW'(a), 8'h00, $sformatf("scan%0d", a));
    idle(0, "scan");

    // back-to-back writes then readback
    xfer(0, 1'b1, 8'h01, 8'h11, "b2b_wr1");
    xfer(0, 1'b1, 8'h02, 8'h22, "b2b_wr2");
    xfer(0, 1'b0, 8'h01, 8'h00, "b2b_rd1");
    xfer(0, 1'b0, 8'h02, 8'h00, "b2b_rd2");
    idle(0, "b2b");

    // abort mid-WAIT by dropping penable
    @(posedge pclk); #1;
    psel_t[2] = 1'b1; penable_t[2] = 1'b0; pwrite_t[2] = 1'b1; paddr_t[2] = 8'h05; pwdata_t[2] = 8'h77;
    @(posedge pclk); #1;
    penable_t[2] = 1'b1;
    @(negedge pclk);
    chk("abort_wait1_pready", get_pready(2), 1'b0);
    @(posedge pclk); #1;
    penable_t[2] = 1'b0;
    @(negedge pclk);
    chk("abort_wait2_pready", get_pready(2), 1'b0);
    @(posedge pclk); #1;
    psel_t[2] = 1'b0;
    repeat (3) begin
      @(negedge pclk);
      chk("abort_idle_pready", get_pready(2), 1'b0);
    end
    xfer(2, 1'b0, 8'h05, 8'h00, "abort_rd");
    idle(2, "abort_rd");

    // reset during WAIT of a write
    @(posedge pclk); #1;
    psel_t[2] = 1'b1; penable_t[2] = 1'b0; pwrite_t[2] = 1'b1; paddr_t[2] = 8'h07; pwdata_t[2] = 8'h55;
    @(posedge pclk); #1;
    penable_t[2] = 1'b1;
    @(negedge pclk);
    chk("rstmid_pready_pre", get_pready(2), 1'b0);
    #1 presetn = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rstmid_pready%0d", k), get_pready(k), 1'b0);
      chk($sformatf("rstmid_slverr%0d", k), get_pslverr(k), 1'b0);
      chk($sformatf("rstmid_prdata%0d", k), get_prdata(k), '0);
      for (int i = 0; i < DEPTH; i++) mem_m[k][i] = '0;
    end
    psel_t[2] = 1'b0; penable_t[2] = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    xfer(2, 1'b0, 8'h07, 8'h00, "rstmid_rd7");
    idle(2, "rstmid_rd7");
    xfer(0, 1'b0, 8'h03, 8'h00, "rstmid_rd_u0");
    idle(0, "rstmid_rd_u0");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
